// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i memory arbiter slice.
package rv32i_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_I,
    ARB_RD_D
  } arb_state_t;

  // Width needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rv32i_sat_counter.sv
// Saturating up-counter with synchronous active-high reset, clear and enable.
module rv32i_sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != MAX))
      count_d = count_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter for a single-port synchronous-read memory.
// Optional grant/conflict statistics when RV32I_ARB_STATS_EN is defined.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int MAX_D_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef RV32I_ARB_STATS_EN
  ,
  output logic [31:0]       i_gnt_cnt,
  output logic [31:0]       d_gnt_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam int                  STREAK_W   = cnt_w(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] streak;
  logic                streak_max;
  logic                unused_addr_lsbs;

  // Data wins a conflict until it has starved fetch for MAX_D_STREAK grants.
  always_comb begin
    streak_max = (streak == STREAK_MAX);
    i_gnt      = ~reset & i_req & (~d_req | streak_max);
    d_gnt      = ~reset & d_req & ~(i_req & streak_max);
  end

  rv32i_sat_counter #(
    .WIDTH (STREAK_W),
    .MAX   (STREAK_MAX)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .clr   (i_gnt | ~i_req),
    .en    (d_gnt & i_req),
    .count (streak)
  );

  // State names the read issued last cycle, i.e. whose data mem_rdata carries now.
  always_comb begin
    state_d = ARB_IDLE;
    if (i_gnt)
      state_d = ARB_RD_I;
    else if (d_gnt && !d_we)
      state_d = ARB_RD_D;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    i_rvalid  = ~reset & (state_q == ARB_RD_I);
    d_rvalid  = ~reset & (state_q == ARB_RD_D);
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    mem_en    = i_gnt | d_gnt;
    mem_addr  = d_gnt ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
    mem_we    = (d_gnt && d_we) ? d_be : '0;
    mem_wdata = d_wdata;
  end

  // Byte offset bits are dropped; alignment is enforced upstream.
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

`ifdef RV32I_ARB_STATS_EN
  rv32i_sat_counter #(.WIDTH(32)) u_i_gnt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (i_gnt),
    .count (i_gnt_cnt)
  );

  rv32i_sat_counter #(.WIDTH(32)) u_d_gnt_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (d_gnt),
    .count (d_gnt_cnt)
  );

  rv32i_sat_counter #(.WIDTH(32)) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (i_req & d_req & ~reset),
    .count (conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a behavioural synchronous-read memory.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef RV32I_ARB_STATS_EN
  logic [31:0] i_gnt_cnt, d_gnt_cnt, conflict_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.ADDR_W(12), .MAX_D_STREAK(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef RV32I_ARB_STATS_EN
    ,
    .i_gnt_cnt    (i_gnt_cnt),
    .d_gnt_cnt    (d_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Unwritten words read back as 0xC0DE0000 | word_index.
  bit [31:0] mem     [1024];
  bit        written [1024];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : (32'hC0DE0000 | 32'(mem_addr));
      end else begin
        logic [31:0] w;
        w = written[mem_addr] ? mem[mem_addr] : (32'hC0DE0000 | 32'(mem_addr));
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr]     <= w;
        written[mem_addr] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  logic [7:0] d_pat;
  logic       exp_d, prev_d;

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Requests during reset must not be granted.
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    check("rst_i_gnt",    32'(i_gnt),    32'd0);
    check("rst_d_gnt",    32'(d_gnt),    32'd0);
    check("rst_mem_en",   32'(mem_en),   32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("noreq_mem_en", 32'(mem_en),   32'd0);
    check("post_rst_irv", 32'(i_rvalid), 32'd0);
    check("post_rst_drv", 32'(d_rvalid), 32'd0);

    // Persistent conflict: fetch word 16, load word 32; expect D,D,D,I,D,D,D,I.
    d_pat  = 8'b1110_1110;
    prev_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 12'h040;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h080;
      #1;
      exp_d = d_pat[7-k];
      check($sformatf("cf%0d_d_gnt", k), 32'(d_gnt), 32'(exp_d));
      check($sformatf("cf%0d_i_gnt", k), 32'(i_gnt), 32'(!exp_d));
      check($sformatf("cf%0d_addr", k),  32'(mem_addr), exp_d ? 32'd32 : 32'd16);
      if (k > 0) begin
        check($sformatf("cf%0d_i_rvalid", k), 32'(i_rvalid), 32'(!prev_d));
        check($sformatf("cf%0d_d_rvalid", k), 32'(d_rvalid), 32'(prev_d));
        check($sformatf("cf%0d_rdata", k), prev_d ? d_rdata : i_rdata,
              prev_d ? 32'hC0DE0020 : 32'hC0DE0010);
      end
      prev_d = exp_d;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("cf_last_i_rvalid", 32'(i_rvalid), 32'd1);
    check("cf_last_d_rvalid", 32'(d_rvalid), 32'd0);
    check("cf_last_i_rdata",  i_rdata,       32'hC0DE0010);
`ifdef RV32I_ARB_STATS_EN
    check("stats_d_gnt",    d_gnt_cnt,    32'd6);
    check("stats_i_gnt",    i_gnt_cnt,    32'd2);
    check("stats_conflict", conflict_cnt, 32'd8);
`endif

    // Fetch-only read of byte address 0x010.
    @(negedge clk);
    i_req = 1'b1; i_addr = 12'h010;
    #1;
    check("f_i_gnt",    32'(i_gnt),    32'd1);
    check("f_d_gnt",    32'(d_gnt),    32'd0);
    check("f_mem_en",   32'(mem_en),   32'd1);
    check("f_mem_addr", 32'(mem_addr), 32'h004);
    check("f_mem_we",   32'(mem_we),   32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("f_i_rvalid", 32'(i_rvalid), 32'd1);
    check("f_i_rdata",  i_rdata,       32'hC0DE0004);
    check("f_d_rvalid", 32'(d_rvalid), 32'd0);
    check("f_mem_en_0", 32'(mem_en),   32'd0);

    // Partial store to word 2.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'h008; d_wdata = 32'hDEADBEEF;
    #1;
    check("s_d_gnt",     32'(d_gnt),    32'd1);
    check("s_mem_en",    32'(mem_en),   32'd1);
    check("s_mem_we",    32'(mem_we),   32'b0011);
    check("s_mem_addr",  32'(mem_addr), 32'h002);
    check("s_mem_wdata", mem_wdata,     32'hDEADBEEF);
    check("s_irv_prev",  32'(i_rvalid), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("s_d_rvalid", 32'(d_rvalid), 32'd0);
    check("s_i_rvalid", 32'(i_rvalid), 32'd0);

    // Back-to-back: fetch 0x000 then load 0x020.
    @(negedge clk);
    i_req = 1'b1; i_addr = 12'h000;
    #1;
    check("bb_i_gnt", 32'(i_gnt),    32'd1);
    check("bb_addr0", 32'(mem_addr), 32'h000);
    @(negedge clk);
    idle_inputs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
    #1;
    check("bb_d_gnt",    32'(d_gnt),    32'd1);
    check("bb_addr1",    32'(mem_addr), 32'h008);
    check("bb_i_rvalid", 32'(i_rvalid), 32'd1);
    check("bb_i_rdata",  i_rdata,       32'hC0DE0000);
    @(negedge clk);
    d_addr = 12'h008;
    #1;
    check("bb_d_rvalid", 32'(d_rvalid), 32'd1);
    check("bb_d_rdata",  d_rdata,       32'hC0DE0008);
    check("bb_i_rv_off", 32'(i_rvalid), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ld_store_rdata", d_rdata, 32'hC0DEBEEF);
    check("ld_store_rv",    32'(d_rvalid), 32'd1);

    // Reset the cycle after a load grant.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h004;
    #1;
    check("mr_d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("mr_d_rvalid_rst", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check("mr_d_rvalid_rst2", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_d_rvalid_after", 32'(d_rvalid), 32'd0);
    check("mr_i_rvalid_after", 32'(i_rvalid), 32'd0);
`ifdef RV32I_ARB_STATS_EN
    check("mr_stats_i", i_gnt_cnt,    32'd0);
    check("mr_stats_d", d_gnt_cnt,    32'd0);
    check("mr_stats_c", conflict_cnt, 32'd0);
`endif

    // First grant after reset: conflict goes to data as at power-up.
    @(negedge clk);
    i_req = 1'b1; i_addr = 12'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h004;
    #1;
    check("pr_d_gnt", 32'(d_gnt), 32'd1);
    check("pr_i_gnt", 32'(i_gnt), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("pr_d_rvalid", 32'(d_rvalid), 32'd1);
    check("pr_d_rdata",  d_rdata,       32'hC0DE0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
